barrel: RTL and testbench

- Registered barrel rotator.
- Each rising clock edge captures either a fresh input word (Load=1) or the current output (Load=0), rotates it left by Select positions, and stores the result in the output register.
- Used as a loadable, self-recirculating rotate register. Repeated cycles with Load=0 keep rotating the stored word.

---
 rtl/barrel_pkg.sv | 17 +
 rtl/barrel_rot_stage.sv | 24 ++
 rtl/barrel.sv | 68 ++++++
 tb/tb_barrel.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared constants and helpers for the barrel rotator.
package barrel_pkg;

    // Default word width of the rotator.
    localparam int BARREL_DATA_SIZE_DEF = 8;

    // Width of the rotate-amount select for a given word width.
    function automatic int barrel_sel_width(input int data_size);
        return $clog2(data_size);
    endfunction

    // True when the word width is a power of two and at least 2.
    function automatic bit barrel_size_ok(input int data_size);
        return (data_size >= 2) && ((data_size & (data_size - 1)) == 0);
    endfunction

endpackage

// File: rtl/barrel_rot_stage.sv
// One fixed-amount stage of the logarithmic rotator.
// When en_i is set the word is rotated left by SHIFT. Otherwise it passes through.
module barrel_rot_stage
    import barrel_pkg::*;
#(
    parameter int data_size = BARREL_DATA_SIZE_DEF,
    parameter int SHIFT     = 1
) (
    input  logic                 en_i,
    input  logic [data_size-1:0] data_i,
    output logic [data_size-1:0] rot_o
);

    // Fixed wiring: the top SHIFT bits wrap around to the bottom.
    always_comb begin
        rot_o = data_i;
        if (en_i) begin
            rot_o = {data_i[data_size-SHIFT-1:0], data_i[data_size-1:data_size-SHIFT]};
        end else begin
            rot_o = data_i;
        end
    end

endmodule

// File: rtl/barrel.sv
// Registered barrel rotator. On each clock edge it captures either Data_in or
// its own output, rotates that word left by Select, and registers the result.
module barrel
    import barrel_pkg::*;
#(
    parameter int data_size = BARREL_DATA_SIZE_DEF,
    localparam int SEL_W    = barrel_sel_width(data_size)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Load,
    input  logic [SEL_W-1:0]     Select,
    input  logic [data_size-1:0] Data_in,
    output logic [data_size-1:0] Data_out
);

    // Refuse to build for widths the stage chain cannot rotate correctly.
    generate
        if (!barrel_size_ok(data_size)) begin : g_bad_size
            $error("barrel: data_size must be a power of two and at least 2");
        end
    endgenerate

    logic [data_size-1:0] data_q;
    logic [data_size-1:0] data_d;
    logic [data_size-1:0] src_s;
    logic [data_size-1:0] stage_s [0:SEL_W];

    // Pick the word to rotate: a fresh load or the recirculated output.
    always_comb begin
        src_s = data_q;
        if (Load) begin
            src_s = Data_in;
        end else begin
            src_s = data_q;
        end
    end

    assign stage_s[0] = src_s;

    // Stage k rotates by 2^k when Select[k] is set; the chain composes any amount.
    generate
        for (genvar k = 0; k < SEL_W; k++) begin : g_stage
            barrel_rot_stage #(
                .data_size (data_size),
                .SHIFT     (2 ** k)
            ) u_stage (
                .en_i   (Select[k]),
                .data_i (stage_s[k]),
                .rot_o  (stage_s[k+1])
            );
        end
    endgenerate

    assign data_d = stage_s[SEL_W];

    // Output register; reset clears it immediately and wins over a coincident edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            data_q <= {data_size{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign Data_out = data_q;

endmodule

// File: tb/tb_barrel.sv
// Directed self-checking bench for the barrel rotator (8-bit and 16-bit builds).
module tb_barrel;

    logic        Clock;
    logic        Reset;
    logic        Load;
    logic [2:0]  Select;
    logic [7:0]  Data_in;
    logic [7:0]  Data_out;
    logic [3:0]  Select16;
    logic [15:0] Data_in16;
    logic [15:0] Data_out16;

    int total;
    int bad;

    barrel #(.data_size(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (Load),
        .Select   (Select),
        .Data_in  (Data_in),
        .Data_out (Data_out)
    );

    barrel #(.data_size(16)) dut16 (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (Load),
        .Select   (Select16),
        .Data_in  (Data_in16),
        .Data_out (Data_out16)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Reference left-rotate for 8 bits: take the upper half of {x,x} << s.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        logic [15:0] t;
        t = {x, x} << s;
        return t[15:8];
    endfunction

    task automatic test_reset();
        #1;
        Reset = 1'b1;
        #1;
        total++;
        if (Data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_async got=%h exp=%h", Data_out, 8'h00);
        end
        total++;
        if (Data_out16 !== 16'h0000) begin
            bad++;
            $display("FAIL reset_async16 got=%h exp=%h", Data_out16, 16'h0000);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (Data_out !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold got=%h exp=%h", Data_out, 8'h00);
            end
        end
        Load = 1'b0;
        Reset = 1'b0;
        tick();
        total++;
        if (Data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_recirc_zero got=%h exp=%h", Data_out, 8'h00);
        end
    endtask

    task automatic test_load();
        Load = 1'b1; Data_in = 8'h81; Select = 3'd1;
        tick();
        total++;
        if (Data_out !== 8'h03) begin
            bad++;
            $display("FAIL load_rot1 got=%h exp=%h", Data_out, 8'h03);
        end
        Data_in = 8'h5A; Select = 3'd0;
        tick();
        total++;
        if (Data_out !== 8'h5A) begin
            bad++;
            $display("FAIL load_rot0 got=%h exp=%h", Data_out, 8'h5A);
        end
    endtask

    task automatic test_recirculate();
        logic [7:0] exp_seq [0:3];
        exp_seq[0] = 8'h0C; exp_seq[1] = 8'h30; exp_seq[2] = 8'hC0; exp_seq[3] = 8'h03;
        Load = 1'b1; Data_in = 8'h03; Select = 3'd0;
        tick();
        Load = 1'b0; Select = 3'd2; Data_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (Data_out !== exp_seq[i]) begin
                bad++;
                $display("FAIL recirc_step%0d got=%h exp=%h", i, Data_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_boundary();
        Load = 1'b1; Data_in = 8'h01; Select = 3'd7;
        tick();
        total++;
        if (Data_out !== 8'h80) begin
            bad++;
            $display("FAIL sel7_rotr1 got=%h exp=%h", Data_out, 8'h80);
        end
        Load = 1'b0; Select = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (Data_out !== 8'h80) begin
                bad++;
                $display("FAIL hold_sel0 got=%h exp=%h", Data_out, 8'h80);
            end
        end
        // Glitch the inputs between edges; only the value at the edge counts.
        #2;
        Load = 1'b1; Data_in = 8'h55; Select = 3'd5;
        #2;
        Load = 1'b0; Select = 3'd0;
        tick();
        total++;
        if (Data_out !== 8'h80) begin
            bad++;
            $display("FAIL between_edges got=%h exp=%h", Data_out, 8'h80);
        end
        Select = 3'd4;
        tick();
        total++;
        if (Data_out !== 8'h08) begin
            bad++;
            $display("FAIL sel4 got=%h exp=%h", Data_out, 8'h08);
        end
    endtask

    task automatic test_reset_mid();
        Load = 1'b0; Select = 3'd1;
        tick();
        total++;
        if (Data_out !== 8'h10) begin
            bad++;
            $display("FAIL pre_reset got=%h exp=%h", Data_out, 8'h10);
        end
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if (Data_out !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_async got=%h exp=%h", Data_out, 8'h00);
        end
        Load = 1'b1; Data_in = 8'hFF; Select = 3'd3;
        tick();
        total++;
        if (Data_out !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_hold got=%h exp=%h", Data_out, 8'h00);
        end
        #2;
        Reset = 1'b0;
        Load = 1'b1; Data_in = 8'hF0; Select = 3'd3;
        tick();
        total++;
        if (Data_out !== 8'h87) begin
            bad++;
            $display("FAIL post_reset_load got=%h exp=%h", Data_out, 8'h87);
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  pats [0:2];
        logic [7:0]  exp8;
        logic [15:0] exp16;
        pats[0] = 8'h01; pats[1] = 8'h96; pats[2] = 8'hFF;
        Load = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 8; s++) begin
                Data_in = pats[d];
                Select = s[2:0];
                tick();
                exp8 = rotl8(pats[d], s);
                total++;
                if (Data_out !== exp8) begin
                    bad++;
                    $display("FAIL sweep8 d=%h s=%0d got=%h exp=%h", pats[d], s, Data_out, exp8);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 16; s++) begin
                Data_in16 = 16'h0001 << i;
                Select16 = s[3:0];
                tick();
                exp16 = 16'h0001 << ((i + s) % 16);
                total++;
                if (Data_out16 !== exp16) begin
                    bad++;
                    $display("FAIL sweep16 bit=%0d s=%0d got=%h exp=%h", i, s, Data_out16, exp16);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        Reset = 1'b0;
        Load = 1'b1;
        Select = 3'd0;
        Data_in = 8'hA5;
        Select16 = 4'd0;
        Data_in16 = 16'h0000;
        test_reset();
        test_load();
        test_recirculate();
        test_boundary();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
